branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 19, program-counter width.
REQ-002 SHALL have parameter OFF_W, default 15, signed branch-offset width (OFF_W <= PC_W).
REQ-003 SHALL have parameter ENTRIES, default 16, BTB depth; power of two, at least 2; IDX_W = log2(ENTRIES).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL have port fetch_valid, input, 1, lookup request this cycle.
REQ-007 SHALL have port fetch_pc, input, PC_W, PC being fetched.
REQ-008 SHALL have port pred_valid, output, 1, prediction-result strobe.
REQ-009 SHALL have port pred_taken, output, 1, predicted direction.
REQ-010 SHALL have port pred_target, output, PC_W, predicted next PC.
REQ-011 SHALL have port resolve_valid, input, 1, branch resolution this cycle.
REQ-012 SHALL have port opcode, input, 5, resolving instruction opcode.
REQ-013 SHALL have ports zero_flag, overflow_a, overflow_s, each input, 1, ALU flags.
REQ-014 SHALL have port resolve_pc, input, PC_W, PC of the resolving instruction.
REQ-015 SHALL have port offset, input, OFF_W, signed two's-complement displacement.
REQ-016 SHALL have port resolve_pred_taken, input, 1, direction that was predicted for this instruction.
REQ-017 SHALL have port resolve_pred_target, input, PC_W, target that was predicted for this instruction.
REQ-018 SHALL have port branch_taken, output, 1, actual direction (registered).
REQ-019 SHALL have port target_address, output, PC_W, actual taken target (registered).
REQ-020 SHALL have port mispredict, output, 1, one-cycle flush pulse.
REQ-021 SHALL have port flush_pc, output, PC_W, correct next PC when mispredict is high.

Function
REQ-022 Direction decode: 01010 always taken; 01011 taken iff zero_flag=1; 01100 taken iff overflow_a OR overflow_s. All other opcodes are non-branches: not taken, no BTB update.
REQ-023 Target = resolve_pc + sign-extended offset, modulo 2^PC_W (wrap, no saturation). Fall-through = resolve_pc + 1, modulo 2^PC_W.
REQ-024 BTB entry fields: valid bit, tag = pc[PC_W-1:IDX_W], 2-bit saturating counter, PC_W-bit target. Entry is indexed by pc[IDX_W-1:0].
REQ-025 Lookup latency: exactly 1 cycle. pred_valid is fetch_valid delayed by 1 cycle.
REQ-026 Lookup result: pred_taken=1 iff the entry is valid, the tag matches, and counter>=2. pred_target = stored target when pred_taken=1, else fetch_pc+1.
REQ-027 Resolution outputs: branch_taken, target_address and mispredict are registered 1 cycle after resolve_valid. branch_taken=0 and mispredict=0 when resolve_valid=0.
REQ-028 mispredict=1 iff the instruction is a branch and either (actual taken != resolve_pred_taken) or (both taken and target != resolve_pred_target). A non-branch with resolve_pred_taken=1 also SHALL raise mispredict.
REQ-029 flush_pc = target when actually taken, else fall-through.
REQ-030 BTB update applies only to branch opcodes with resolve_valid=1:
- Hit, taken: counter increments, saturating at 3; target is overwritten.
- Hit, not taken: counter decrements, saturating at 0.
- Miss, taken: entry is allocated/replaced with counter=2 and the new tag and target.
- Miss, not taken: no change.
REQ-031 Simultaneous fetch and resolve to the same index: the lookup SHALL return the pre-update contents (read-before-write). The update completes in the same edge.

Reset
REQ-032 While rst_n=0: all valid bits cleared, all counters set to 1. pred_valid, pred_taken, branch_taken, mispredict = 0. pred_target, target_address, flush_pc = 0.
REQ-033 Reset asserted mid-operation SHALL abort any pending pred_valid or mispredict pulse.
REQ-034 The first edge after rst_n rises SHALL behave as a normal cycle.

Verification
REQ-035 Opcode 01010, resolve_pc=138, offset=5, pred_taken=0 -> branch_taken=1, target_address=143, mispredict=1, flush_pc=143; entry 10 allocated with counter=2.
REQ-036 Then fetch_pc=138 -> next cycle pred_valid=1, pred_taken=1, pred_target=143. Resolve the same branch with correct prediction -> mispredict=0, counter=3.
REQ-037 Opcode 01011, zero_flag=0, pc=138, pred_taken=1, pred_target=143 -> branch_taken=0, mispredict=1, flush_pc=139, counter decremented.
REQ-038 Opcode 01100, overflow_s=1, pc=138, offset=15'h7FFB (-5) -> target_address=133. pc=19'h7FFFF, offset=2 -> target_address=1 (wrap).
REQ-039 Counter saturation: 4 taken resolutions hold the counter at 3; 4 not-taken resolutions hold it at 0. Aliasing pc=154 (same index as 138, different tag) -> lookup miss, pred_taken=0.
REQ-040 Assert rst_n=0 while mispredict is pending -> all outputs 0 asynchronously; a subsequent fetch of 138 -> pred_taken=0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch predictor: one-cycle BTB lookup with 2-bit saturating counters, plus
// registered branch resolution that raises a flush and trains the BTB.
module branch_predict_unit #(
    parameter int PC_W    = 19,
    parameter int OFF_W   = 15,
    parameter int ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             resolve_valid,
    input  logic [4:0]       opcode,
    input  logic             zero_flag,
    input  logic             overflow_a,
    input  logic             overflow_s,
    input  logic [PC_W-1:0]  resolve_pc,
    input  logic [OFF_W-1:0] offset,
    input  logic             resolve_pred_taken,
    input  logic [PC_W-1:0]  resolve_pred_target,
    output logic             branch_taken,
    output logic [PC_W-1:0]  target_address,
    output logic             mispredict,
    output logic [PC_W-1:0]  flush_pc
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;

    localparam logic [4:0] OP_JMP = 5'b01010;
    localparam logic [4:0] OP_BEQ = 5'b01011;
    localparam logic [4:0] OP_BOV = 5'b01100;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [1:0]         ctr_q [ENTRIES];
    logic [PC_W-1:0]    tgt_q [ENTRIES];

    logic            pred_valid_q, pred_taken_q;
    logic [PC_W-1:0] pred_target_q;
    logic            branch_taken_q, mispredict_q;
    logic [PC_W-1:0] target_address_q, flush_pc_q;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             pred_taken_d;
    logic [PC_W-1:0]  pred_target_d;

    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             is_branch;
    logic             act_taken;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  br_target;
    logic [PC_W-1:0]  fall_through;
    logic             upd_en;
    logic [1:0]       ctr_d;
    logic [PC_W-1:0]  tgt_d;

    logic            branch_taken_d, mispredict_d;
    logic [PC_W-1:0] target_address_d, flush_pc_d;

    // Lookup reads the pre-update BTB contents, giving read-before-write
    // when a fetch and a resolve hit the same index in one cycle.
    assign f_idx         = fetch_pc[IDX_W-1:0];
    assign f_tag         = fetch_pc[PC_W-1:IDX_W];
    assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken_d  = fetch_valid && f_hit && ctr_q[f_idx][1];
    assign pred_target_d = pred_taken_d ? tgt_q[f_idx] : fetch_pc + PC_W'(1);

    assign r_idx        = resolve_pc[IDX_W-1:0];
    assign r_tag        = resolve_pc[PC_W-1:IDX_W];
    assign r_hit        = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign off_ext      = PC_W'($signed(offset));
    assign br_target    = resolve_pc + off_ext;
    assign fall_through = resolve_pc + PC_W'(1);

    always_comb begin
        is_branch = 1'b1;
        act_taken = 1'b0;
        case (opcode)
            OP_JMP:  act_taken = 1'b1;
            OP_BEQ:  act_taken = zero_flag;
            OP_BOV:  act_taken = overflow_a | overflow_s;
            default: is_branch = 1'b0;
        endcase
    end

    // A miss that is not taken leaves the BTB untouched.
    assign upd_en = resolve_valid && is_branch && (r_hit || act_taken);

    always_comb begin
        ctr_d = ctr_q[r_idx];
        tgt_d = tgt_q[r_idx];
        if (!r_hit) begin
            ctr_d = 2'd2;
            tgt_d = br_target;
        end else if (act_taken) begin
            if (ctr_q[r_idx] != 2'd3) begin
                ctr_d = ctr_q[r_idx] + 2'd1;
            end
            tgt_d = br_target;
        end else if (ctr_q[r_idx] != 2'd0) begin
            ctr_d = ctr_q[r_idx] - 2'd1;
        end
    end

    always_comb begin
        branch_taken_d   = resolve_valid && is_branch && act_taken;
        mispredict_d     = 1'b0;
        target_address_d = target_address_q;
        flush_pc_d       = flush_pc_q;
        if (resolve_valid) begin
            target_address_d = br_target;
            flush_pc_d       = act_taken ? br_target : fall_through;
            if (is_branch) begin
                mispredict_d = (act_taken != resolve_pred_taken) ||
                               (act_taken && resolve_pred_taken &&
                                (br_target != resolve_pred_target));
            end else begin
                mispredict_d = resolve_pred_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'd1;
                tgt_q[i]   <= '0;
            end
        end else if (upd_en) begin
            valid_q[r_idx] <= 1'b1;
            tag_q[r_idx]   <= r_tag;
            ctr_q[r_idx]   <= ctr_d;
            tgt_q[r_idx]   <= tgt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q     <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_target_q    <= '0;
            branch_taken_q   <= 1'b0;
            mispredict_q     <= 1'b0;
            target_address_q <= '0;
            flush_pc_q       <= '0;
        end else begin
            pred_valid_q     <= fetch_valid;
            pred_taken_q     <= pred_taken_d;
            pred_target_q    <= pred_target_d;
            branch_taken_q   <= branch_taken_d;
            mispredict_q     <= mispredict_d;
            target_address_q <= target_address_d;
            flush_pc_q       <= flush_pc_d;
        end
    end

    assign pred_valid     = pred_valid_q;
    assign pred_taken     = pred_taken_q;
    assign pred_target    = pred_target_q;
    assign branch_taken   = branch_taken_q;
    assign mispredict     = mispredict_q;
    assign target_address = target_address_q;
    assign flush_pc       = flush_pc_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural BTB model.
module tb_branch_predict_unit;
    localparam int PC_W    = 19;
    localparam int OFF_W   = 15;
    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int PC_MASK = (1 << PC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             fetch_valid;
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             resolve_valid;
    logic [4:0]       opcode;
    logic             zero_flag;
    logic             overflow_a;
    logic             overflow_s;
    logic [PC_W-1:0]  resolve_pc;
    logic [OFF_W-1:0] offset;
    logic             resolve_pred_taken;
    logic [PC_W-1:0]  resolve_pred_target;
    logic             branch_taken;
    logic [PC_W-1:0]  target_address;
    logic             mispredict;
    logic [PC_W-1:0]  flush_pc;

    int compared   = 0;
    int mismatched = 0;

    bit mValid [ENTRIES];
    int mOwner [ENTRIES];
    int mCtr   [ENTRIES];
    int mTgt   [ENTRIES];

    bit inReset;
    bit expPV, expPT, expBT, expMis;
    int expPTgt, expTA, expFl;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .ENTRIES(ENTRIES)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .fetch_valid         (fetch_valid),
        .fetch_pc            (fetch_pc),
        .pred_valid          (pred_valid),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target),
        .resolve_valid       (resolve_valid),
        .opcode              (opcode),
        .zero_flag           (zero_flag),
        .overflow_a          (overflow_a),
        .overflow_s          (overflow_s),
        .resolve_pc          (resolve_pc),
        .offset              (offset),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .branch_taken        (branch_taken),
        .target_address      (target_address),
        .mispredict          (mispredict),
        .flush_pc            (flush_pc)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int wrapAdd(input int pc, input int off);
        int soff;
        soff = (off >= (1 << (OFF_W - 1))) ? off - (1 << OFF_W) : off;
        return (pc + soff) & PC_MASK;
    endfunction

    function automatic bit isBranch(input int op);
        return (op == 10) || (op == 11) || (op == 12);
    endfunction

    function automatic bit actualTaken(input int op, input bit zf, input bit oa, input bit os);
        if (op == 10) return 1'b1;
        if (op == 11) return zf;
        if (op == 12) return oa || os;
        return 1'b0;
    endfunction

    function automatic bit modelHit(input int pc);
        int idx;
        idx = pc % ENTRIES;
        return mValid[idx] && ((mOwner[idx] >> IDX_W) == (pc >> IDX_W));
    endfunction

    // Reference model: expectations come from inputs seen at the edge and the
    // BTB state before that edge; the DUT is checked just after the edge.
    always begin : compareProc
        int idx, fpc, rpc, tgt;
        bit bt;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mValid[i] = 1'b0;
                mCtr[i]   = 1;
            end
            inReset = 1'b1;
            expPV = 0; expPT = 0; expBT = 0; expMis = 0;
            expPTgt = 0; expTA = 0; expFl = 0;
        end else begin
            inReset = 1'b0;
            expPV = fetch_valid;
            expPT = 1'b0;
            expPTgt = 0;
            if (fetch_valid) begin
                fpc = int'(fetch_pc);
                idx = fpc % ENTRIES;
                expPT   = modelHit(fpc) && (mCtr[idx] >= 2);
                expPTgt = expPT ? mTgt[idx] : (fpc + 1) & PC_MASK;
            end
            expBT  = 1'b0;
            expMis = 1'b0;
            if (resolve_valid) begin
                rpc = int'(resolve_pc);
                tgt = wrapAdd(rpc, int'(offset));
                bt  = isBranch(int'(opcode)) &&
                      actualTaken(int'(opcode), zero_flag, overflow_a, overflow_s);
                expBT = bt;
                expTA = tgt;
                expFl = bt ? tgt : (rpc + 1) & PC_MASK;
                if (isBranch(int'(opcode))) begin
                    expMis = (bt != resolve_pred_taken) ||
                             (bt && resolve_pred_taken && tgt != int'(resolve_pred_target));
                    idx = rpc % ENTRIES;
                    if (modelHit(rpc)) begin
                        if (bt) begin
                            mCtr[idx] = (mCtr[idx] < 3) ? mCtr[idx] + 1 : 3;
                            mTgt[idx] = tgt;
                        end else begin
                            mCtr[idx] = (mCtr[idx] > 0) ? mCtr[idx] - 1 : 0;
                        end
                    end else if (bt) begin
                        mValid[idx] = 1'b1;
                        mOwner[idx] = rpc;
                        mCtr[idx]   = 2;
                        mTgt[idx]   = tgt;
                    end
                end else begin
                    expMis = resolve_pred_taken;
                end
            end
        end
        #1;
        checkOutput("pred_valid", int'(pred_valid), int'(expPV));
        checkOutput("branch_taken", int'(branch_taken), int'(expBT));
        checkOutput("mispredict", int'(mispredict), int'(expMis));
        if (expPV || inReset) begin
            checkOutput("pred_taken", int'(pred_taken), int'(expPT));
            checkOutput("pred_target", int'(pred_target), expPTgt);
        end
        if (expBT || inReset) checkOutput("target_address", int'(target_address), expTA);
        if (expMis || inReset) checkOutput("flush_pc", int'(flush_pc), expFl);
    end

    task automatic applyStimulus(input bit fv, input int fpc, input bit rv, input int op,
                                 input bit zf, input bit oa, input bit os, input int rpc,
                                 input int off, input bit pt, input int ptgt);
        @(negedge clk);
        fetch_valid         = fv;
        fetch_pc            = PC_W'(fpc);
        resolve_valid       = rv;
        opcode              = 5'(op);
        zero_flag           = zf;
        overflow_a          = oa;
        overflow_s          = os;
        resolve_pc          = PC_W'(rpc);
        offset              = OFF_W'(off);
        resolve_pred_taken  = pt;
        resolve_pred_target = PC_W'(ptgt);
        @(negedge clk);
        fetch_valid   = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic resolveBr(input int op, input bit zf, input bit oa, input bit os,
                             input int pc, input int off, input bit pt, input int ptgt);
        applyStimulus(1'b0, 0, 1'b1, op, zf, oa, os, pc, off, pt, ptgt);
    endtask

    task automatic fetchPc(input int pc);
        applyStimulus(1'b1, pc, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    function automatic int randPc();
        if ($urandom_range(0, 3) == 0) return int'($urandom) & PC_MASK;
        return int'($urandom_range(0, 63));
    endfunction

    initial begin
        rst_n = 1'b0;
        fetch_valid = 0; fetch_pc = '0; resolve_valid = 0; opcode = '0;
        zero_flag = 0; overflow_a = 0; overflow_s = 0; resolve_pc = '0;
        offset = '0; resolve_pred_taken = 0; resolve_pred_target = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset pred_valid", int'(pred_valid), 0);
        checkOutput("reset pred_target", int'(pred_target), 0);
        checkOutput("reset flush_pc", int'(flush_pc), 0);
        rst_n = 1'b1;

        resolveBr(10, 0, 0, 0, 138, 5, 0, 0);
        checkOutput("jmp branch_taken", int'(branch_taken), 1);
        checkOutput("jmp target_address", int'(target_address), 143);
        checkOutput("jmp mispredict", int'(mispredict), 1);
        checkOutput("jmp flush_pc", int'(flush_pc), 143);
        checkOutput("model ctr alloc", mCtr[10], 2);

        fetchPc(138);
        checkOutput("hit pred_valid", int'(pred_valid), 1);
        checkOutput("hit pred_taken", int'(pred_taken), 1);
        checkOutput("hit pred_target", int'(pred_target), 143);

        resolveBr(10, 0, 0, 0, 138, 5, 1, 143);
        checkOutput("correct mispredict", int'(mispredict), 0);
        checkOutput("model ctr inc", mCtr[10], 3);

        resolveBr(11, 0, 0, 0, 138, 5, 1, 143);
        checkOutput("beq branch_taken", int'(branch_taken), 0);
        checkOutput("beq mispredict", int'(mispredict), 1);
        checkOutput("beq flush_pc", int'(flush_pc), 139);
        checkOutput("model ctr dec", mCtr[10], 2);

        resolveBr(12, 0, 0, 1, 138, 'h7FFB, 0, 0);
        checkOutput("neg offset target", int'(target_address), 133);
        resolveBr(12, 0, 1, 0, 'h7FFFF, 2, 0, 0);
        checkOutput("wrap target", int'(target_address), 1);

        repeat (4) resolveBr(10, 0, 0, 0, 138, 5, 1, 143);
        checkOutput("model ctr sat hi", mCtr[10], 3);
        fetchPc(138);
        checkOutput("sat hi pred_taken", int'(pred_taken), 1);
        repeat (4) resolveBr(11, 0, 0, 0, 138, 5, 0, 0);
        checkOutput("model ctr sat lo", mCtr[10], 0);
        fetchPc(138);
        checkOutput("sat lo pred_taken", int'(pred_taken), 0);
        checkOutput("sat lo pred_target", int'(pred_target), 139);

        repeat (2) resolveBr(10, 0, 0, 0, 138, 5, 1, 143);
        fetchPc(154);
        checkOutput("alias pred_taken", int'(pred_taken), 0);
        checkOutput("alias pred_target", int'(pred_target), 155);

        applyStimulus(1'b1, 154, 1'b1, 10, 0, 0, 0, 154, 7, 0, 0);
        checkOutput("rbw pred_taken", int'(pred_taken), 0);
        checkOutput("rbw target_address", int'(target_address), 161);
        fetchPc(154);
        checkOutput("after rbw pred_taken", int'(pred_taken), 1);
        checkOutput("after rbw pred_target", int'(pred_target), 161);

        resolveBr(0, 0, 0, 0, 200, 3, 1, 250);
        checkOutput("nonbranch mispredict", int'(mispredict), 1);
        checkOutput("nonbranch flush_pc", int'(flush_pc), 201);

        @(negedge clk);
        resolve_valid = 1'b1; opcode = 5'b01011; zero_flag = 1'b1;
        resolve_pc = PC_W'(154); offset = OFF_W'(4); resolve_pred_taken = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pending mispredict", int'(mispredict), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async mispredict", int'(mispredict), 0);
        checkOutput("async branch_taken", int'(branch_taken), 0);
        checkOutput("async target_address", int'(target_address), 0);
        @(negedge clk);
        resolve_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fetchPc(138);
        checkOutput("post reset pred_taken", int'(pred_taken), 0);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                fetch_valid = 1'b0;
                resolve_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                continue;
            end
            fetch_valid = 1'($urandom_range(0, 1));
            fetch_pc    = PC_W'(randPc());
            resolve_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2: opcode = 5'b01010;
                3, 4, 5: opcode = 5'b01011;
                6, 7:    opcode = 5'b01100;
                default: opcode = 5'($urandom_range(0, 31));
            endcase
            zero_flag  = 1'($urandom_range(0, 1));
            overflow_a = 1'($urandom_range(0, 1));
            overflow_s = 1'($urandom_range(0, 1));
            resolve_pc = PC_W'(randPc());
            offset     = OFF_W'($urandom);
            resolve_pred_taken = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                resolve_pred_target = PC_W'(wrapAdd(int'(resolve_pc), int'(offset)));
            else
                resolve_pred_target = PC_W'($urandom);
        end
        @(negedge clk);
        fetch_valid = 1'b0;
        resolve_valid = 1'b0;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
